// File: rtl/cpu_pkg.sv
// Shared defaults and types for the CPU register file slice.
package cpu_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 8;
  localparam logic [RF_DATA_W-1:0] RF_SP_RESET = '1;

  typedef logic [$clog2(RF_NUM_REGS)-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_WR_BUSY,
    ERR_LD_UNTRACKED,
    ERR_LD_REISSUE,
    ERR_WR_COLLIDE,
    ERR_SP_DROP
  } err_cause_e;

endpackage

// File: rtl/cpu_regfile_sb_if.sv
// Bus between the decoder/control FSM (master) and the register file (slave).
interface cpu_regfile_sb_if import cpu_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_sel_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_sel_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              sp_inc;
  logic              sp_dec;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_issue_sel;
  logic              ld_done;
  logic [ADDR_W-1:0] ld_done_sel;
  logic [DATA_W-1:0] ld_data;
  logic              busy_a;
  logic              busy_b;
  logic [NUM_REGS-1:0] busy_vec;
  logic              err;

  modport master (
    output wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b, sp_inc, sp_dec,
           ld_issue, ld_issue_sel, ld_done, ld_done_sel, ld_data,
    input  rd_data_a, rd_data_b, busy_a, busy_b, busy_vec, err
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b, sp_inc, sp_dec,
           ld_issue, ld_issue_sel, ld_done, ld_done_sel, ld_data,
    output rd_data_a, rd_data_b, busy_a, busy_b, busy_vec, err
  );

endinterface

// File: rtl/cpu_scoreboard.sv
// Per-register busy tracking for outstanding memory loads.
module cpu_scoreboard import cpu_pkg::*; #(
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_issue_sel,
  input  logic                ld_done,
  input  logic [ADDR_W-1:0]   ld_done_sel,
  input  logic [ADDR_W-1:0]   rd_sel_a,
  input  logic [ADDR_W-1:0]   rd_sel_b,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                busy_a,
  output logic                busy_b,
  output logic                sb_err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                same_idx;

  always_comb begin
    busy_d   = busy_q;
    same_idx = ld_issue && ld_done && (ld_issue_sel == ld_done_sel);
    if (ld_done)  busy_d[ld_done_sel]  = 1'b0;
    // Issue applied after done so a same-cycle turnover keeps the new load tracked.
    if (ld_issue) busy_d[ld_issue_sel] = 1'b1;
    sb_err = (ld_done && !busy_q[ld_done_sel]) ||
             (ld_issue && busy_q[ld_issue_sel] && !same_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
  assign busy_a   = busy_q[rd_sel_a];
  assign busy_b   = busy_q[rd_sel_b];

endmodule

// File: rtl/cpu_regfile_sb.sv
// Two-read-port register file with stack-pointer adjust, optional write
// bypass and a load scoreboard for read-after-load stalls.
module cpu_regfile_sb import cpu_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int SP_IDX   = NUM_REGS - 1,
  parameter logic [DATA_W-1:0] SP_RESET = '1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_regfile_sb_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SP_SEL = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                sb_err;
  logic                err_q, err_d;
  logic                sp_adj, sp_blocked;

  cpu_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_issue     (bus.ld_issue),
    .ld_issue_sel (bus.ld_issue_sel),
    .ld_done      (bus.ld_done),
    .ld_done_sel  (bus.ld_done_sel),
    .rd_sel_a     (bus.rd_sel_a),
    .rd_sel_b     (bus.rd_sel_b),
    .busy_vec     (busy),
    .busy_a       (bus.busy_a),
    .busy_b       (bus.busy_b),
    .sb_err       (sb_err)
  );

  always_comb begin
    regs_d     = regs_q;
    sp_adj     = bus.sp_inc ^ bus.sp_dec;
    sp_blocked = busy[SP_SEL] ||
                 (bus.wr_en && bus.wr_sel == SP_SEL) ||
                 (bus.ld_done && bus.ld_done_sel == SP_SEL);
    // Lowest priority first so later assignments override.
    if (sp_adj && !sp_blocked)
      regs_d[SP_SEL] = bus.sp_inc ? regs_q[SP_SEL] + DATA_W'(1)
                                  : regs_q[SP_SEL] - DATA_W'(1);
    if (bus.wr_en && !busy[bus.wr_sel]) regs_d[bus.wr_sel] = bus.wr_data;
    if (bus.ld_done) regs_d[bus.ld_done_sel] = bus.ld_data;
    err_d = sb_err ||
            (bus.wr_en && busy[bus.wr_sel]) ||
            (bus.wr_en && bus.ld_done && bus.wr_sel == bus.ld_done_sel) ||
            (sp_adj && sp_blocked);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  // regs_d already holds the prioritised next value, so it is the bypass source.
  generate
    if (BYPASS) begin : g_bypass
      assign bus.rd_data_a = regs_d[bus.rd_sel_a];
      assign bus.rd_data_b = regs_d[bus.rd_sel_b];
    end else begin : g_stored
      assign bus.rd_data_a = regs_q[bus.rd_sel_a];
      assign bus.rd_data_b = regs_q[bus.rd_sel_b];
    end
  endgenerate

  assign bus.busy_vec = busy;
  assign bus.err      = err_q;

endmodule
